// File: rtl/bus_dev_fifo.sv
// Per-device FIFO pair between one device and the bus: a TX FIFO the bus drains and an
// ID-filtered RX FIFO the device reads. Both are show-ahead with counts and sticky error flags.
module bus_dev_fifo #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dev_wr,
  input  logic [pckg_sz-1:0]       dev_din,
  output logic                     dev_full,
  input  logic                     dev_rd,
  output logic [pckg_sz-1:0]       dev_dout,
  output logic                     dev_valid,
  output logic                     pndng,
  output logic [pckg_sz-1:0]       D_pop,
  input  logic                     pop,
  input  logic                     push,
  input  logic [pckg_sz-1:0]       D_push,
  output logic [$clog2(depth):0]   tx_count,
  output logic [$clog2(depth):0]   rx_count,
  output logic [3:0]               err_flags,
  input  logic                     clr_flags,
  output logic [7:0]               drop_cnt
);

  localparam int aw = $clog2(depth);
  localparam int pw = aw + 1;
  localparam logic [pw-1:0] full_cnt = pw'(depth);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [pw-1:0]      tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;

  logic tx_empty, tx_full, tx_wr_ok, tx_pop_ok, tx_ovf_ev, tx_udf_ev;
  logic rx_empty, rx_full, rx_match, rx_push_ok, rx_rd_ok, rx_ovf_ev, rx_udf_ev, rx_drop;
  logic [3:0] err_new;

  assign tx_count = tx_wr_ptr - tx_rd_ptr;
  assign rx_count = rx_wr_ptr - rx_rd_ptr;
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == full_cnt);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == full_cnt);

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign tx_pop_ok = pop && !tx_empty;
  assign tx_wr_ok  = dev_wr && (!tx_full || pop);
  assign tx_ovf_ev = dev_wr && tx_full && !pop;
  assign tx_udf_ev = pop && tx_empty;

  assign rx_match   = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast);
  assign rx_drop    = push && !rx_match;
  assign rx_rd_ok   = dev_rd && !rx_empty;
  assign rx_push_ok = push && rx_match && (!rx_full || dev_rd);
  assign rx_ovf_ev  = push && rx_match && rx_full && !dev_rd;
  assign rx_udf_ev  = dev_rd && rx_empty;

  assign err_new = {rx_ovf_ev, rx_udf_ev, tx_ovf_ev, tx_udf_ev};

  assign dev_full  = tx_full;
  assign pndng     = !tx_empty;
  assign dev_valid = !rx_empty;
  // Heads are gated so stale RAM contents never reach the outputs while empty.
  assign D_pop     = tx_empty ? '0 : tx_mem[tx_rd_ptr[aw-1:0]];
  assign dev_dout  = rx_empty ? '0 : rx_mem[rx_rd_ptr[aw-1:0]];

  always_ff @(posedge clk) begin
    if (tx_wr_ok)   tx_mem[tx_wr_ptr[aw-1:0]] <= dev_din;
    if (rx_push_ok) rx_mem[rx_wr_ptr[aw-1:0]] <= D_push;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      err_flags <= '0;
      drop_cnt  <= '0;
    end else begin
      if (tx_wr_ok)   tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop_ok)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_rd_ok)   rx_rd_ptr <= rx_rd_ptr + 1'b1;
      // A clear loses to an error raised in the same cycle.
      err_flags <= clr_flags ? err_new : (err_flags | err_new);
      if (clr_flags)
        drop_cnt <= '0;
      else if (rx_drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Directed bench for bus_dev_fifo (depth 8, id 2): a vector table for single-cycle
// behaviour plus hand sequences for fill/wrap and asynchronous mid-cycle reset.
module tb_bus_dev_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev_wr, dev_rd, pop, push, clr_flags;
  logic [15:0] dev_din, D_push;
  logic        dev_full, dev_valid, pndng;
  logic [15:0] dev_dout, D_pop;
  logic [3:0]  tx_count, rx_count, err_flags;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  bus_dev_fifo #(.pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .dev_wr(dev_wr), .dev_din(dev_din), .dev_full(dev_full),
    .dev_rd(dev_rd), .dev_dout(dev_dout), .dev_valid(dev_valid),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .tx_count(tx_count), .rx_count(rx_count),
    .err_flags(err_flags), .clr_flags(clr_flags), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] din;
    logic        rd;
    logic        pp;
    logic        ps;
    logic [15:0] dps;
    logic        clr;
    logic        e_pndng;
    logic [15:0] e_dpop;
    logic [3:0]  e_txc;
    logic        e_valid;
    logic [15:0] e_dout;
    logic [3:0]  e_rxc;
    logic [3:0]  e_err;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic wr, logic [15:0] din, logic rd, logic pp, logic ps,
                              logic [15:0] dps, logic clr, logic e_pndng, logic [15:0] e_dpop,
                              logic [3:0] e_txc, logic e_valid, logic [15:0] e_dout,
                              logic [3:0] e_rxc, logic [3:0] e_err, logic [7:0] e_drop);
    vec_t v;
    v.wr = wr; v.din = din; v.rd = rd; v.pp = pp; v.ps = ps; v.dps = dps; v.clr = clr;
    v.e_pndng = e_pndng; v.e_dpop = e_dpop; v.e_txc = e_txc; v.e_valid = e_valid;
    v.e_dout = e_dout; v.e_rxc = e_rxc; v.e_err = e_err; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    dev_wr = 0; dev_din = '0; dev_rd = 0; pop = 0; push = 0; D_push = '0; clr_flags = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    dev_wr = v.wr; dev_din = v.din; dev_rd = v.rd; pop = v.pp;
    push = v.ps; D_push = v.dps; clr_flags = v.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".pndng"}, 32'(pndng), 0);
    checkOutput({tag, ".dev_valid"}, 32'(dev_valid), 0);
    checkOutput({tag, ".dev_full"}, 32'(dev_full), 0);
    checkOutput({tag, ".D_pop"}, 32'(D_pop), 0);
    checkOutput({tag, ".dev_dout"}, 32'(dev_dout), 0);
    checkOutput({tag, ".tx_count"}, 32'(tx_count), 0);
    checkOutput({tag, ".rx_count"}, 32'(rx_count), 0);
    checkOutput({tag, ".err_flags"}, 32'(err_flags), 0);
    checkOutput({tag, ".drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  initial begin
    logic [15:0] order [8];

    //            wr din      rd pp ps dps      clr | pnd dpop     txc val dout     rxc err      drop
    vecs[0]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 16'h0000, 0,  0, 16'h0000, 0, 4'b0000, 0);
    vecs[1]  = mk(1, 16'h0155, 0, 0, 0, 16'h0000, 0,  1, 16'h0155, 1,  0, 16'h0000, 0, 4'b0000, 0);
    vecs[2]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0,  0, 16'h0000, 0,  0, 16'h0000, 0, 4'b0000, 0);
    vecs[3]  = mk(0, 16'h0000, 0, 0, 1, 16'h0211, 0,  0, 16'h0000, 0,  1, 16'h0211, 1, 4'b0000, 0);
    vecs[4]  = mk(0, 16'h0000, 0, 0, 1, 16'h0322, 0,  0, 16'h0000, 0,  1, 16'h0211, 1, 4'b0000, 1);
    vecs[5]  = mk(0, 16'h0000, 0, 0, 1, 16'hFF33, 0,  0, 16'h0000, 0,  1, 16'h0211, 2, 4'b0000, 1);
    vecs[6]  = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0,  0, 16'h0000, 0,  1, 16'hFF33, 1, 4'b0000, 1);
    vecs[7]  = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0,  0, 16'h0000, 0,  0, 16'h0000, 0, 4'b0000, 1);
    vecs[8]  = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 0,  0, 16'h0000, 0,  0, 16'h0000, 0, 4'b0101, 1);
    vecs[9]  = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 1,  0, 16'h0000, 0,  0, 16'h0000, 0, 4'b0000, 0);
    vecs[10] = mk(1, 16'h0A0A, 0, 1, 0, 16'h0000, 0,  1, 16'h0A0A, 1,  0, 16'h0000, 0, 4'b0001, 0);
    vecs[11] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 1,  0, 16'h0000, 0,  0, 16'h0000, 0, 4'b0100, 0);
    vecs[12] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 1,  0, 16'h0000, 0,  0, 16'h0000, 0, 4'b0000, 0);
    vecs[13] = mk(0, 16'h0000, 1, 0, 1, 16'h0201, 0,  0, 16'h0000, 0,  1, 16'h0201, 1, 4'b0100, 0);
    vecs[14] = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 1,  0, 16'h0000, 0,  0, 16'h0000, 0, 4'b0000, 0);

    idleInputs();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    checkZero("reset_hold");
    @(negedge clk);
    reset = 1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d.pndng", i), 32'(pndng), 32'(vecs[i].e_pndng));
      checkOutput($sformatf("v%0d.D_pop", i), 32'(D_pop), 32'(vecs[i].e_dpop));
      checkOutput($sformatf("v%0d.tx_count", i), 32'(tx_count), 32'(vecs[i].e_txc));
      checkOutput($sformatf("v%0d.dev_full", i), 32'(dev_full), 32'(vecs[i].e_txc == 4'd8));
      checkOutput($sformatf("v%0d.dev_valid", i), 32'(dev_valid), 32'(vecs[i].e_valid));
      checkOutput($sformatf("v%0d.dev_dout", i), 32'(dev_dout), 32'(vecs[i].e_dout));
      checkOutput($sformatf("v%0d.rx_count", i), 32'(rx_count), 32'(vecs[i].e_rxc));
      checkOutput($sformatf("v%0d.err_flags", i), 32'(err_flags), 32'(vecs[i].e_err));
      checkOutput($sformatf("v%0d.drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].e_drop));
    end
    idleInputs();

    // Advance TX pointers to 7 so the fill below crosses the pointer wrap.
    for (int i = 0; i < 5; i++) begin
      dev_wr = 1; dev_din = 16'h0500 + 16'(i);
      @(posedge clk); #1;
      dev_wr = 0;
      checkOutput($sformatf("prime%0d.D_pop", i), 32'(D_pop), 32'(16'h0500 + 16'(i)));
      pop = 1;
      @(posedge clk); #1;
      pop = 0;
      checkOutput($sformatf("prime%0d.pndng", i), 32'(pndng), 0);
    end

    for (int i = 0; i < 8; i++) begin
      dev_wr = 1; dev_din = 16'h1000 + 16'(i);
      @(posedge clk); #1;
      checkOutput($sformatf("fill%0d.tx_count", i), 32'(tx_count), 32'(i + 1));
      checkOutput($sformatf("fill%0d.dev_full", i), 32'(dev_full), 32'(i == 7));
    end
    dev_din = 16'h1008;
    @(posedge clk); #1;
    dev_wr = 0;
    checkOutput("ovf.tx_count", 32'(tx_count), 8);
    checkOutput("ovf.err_flags", 32'(err_flags), 32'(4'b0010));
    checkOutput("ovf.D_pop", 32'(D_pop), 32'(16'h1000));

    dev_wr = 1; dev_din = 16'h2000; pop = 1;
    @(posedge clk); #1;
    dev_wr = 0; pop = 0;
    checkOutput("fullrw.tx_count", 32'(tx_count), 8);
    checkOutput("fullrw.D_pop", 32'(D_pop), 32'(16'h1001));
    checkOutput("fullrw.err_flags", 32'(err_flags), 32'(4'b0010));

    for (int i = 0; i < 7; i++) order[i] = 16'h1001 + 16'(i);
    order[7] = 16'h2000;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain%0d.D_pop", i), 32'(D_pop), 32'(order[i]));
      pop = 1;
      @(posedge clk); #1;
      pop = 0;
    end
    checkOutput("drain.pndng", 32'(pndng), 0);
    checkOutput("drain.tx_count", 32'(tx_count), 0);

    clr_flags = 1;
    @(posedge clk); #1;
    clr_flags = 0;
    checkOutput("clr.err_flags", 32'(err_flags), 0);

    for (int i = 0; i < 5; i++) begin
      push = 1; D_push = 16'hFF00 + 16'(i);
      @(posedge clk); #1;
    end
    push = 1; D_push = 16'h0700; pop = 1;
    @(posedge clk); #1;
    idleInputs();
    checkOutput("prerst.rx_count", 32'(rx_count), 5);
    checkOutput("prerst.dev_dout", 32'(dev_dout), 32'(16'hFF00));
    checkOutput("prerst.drop_cnt", 32'(drop_cnt), 1);
    checkOutput("prerst.err_flags", 32'(err_flags), 32'(4'b0001));

    @(negedge clk);
    #2;
    reset = 0;
    #1;
    checkZero("async_rst");
    @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    checkOutput("postrst.rx_count", 32'(rx_count), 0);
    checkOutput("postrst.tx_count", 32'(tx_count), 0);
    checkOutput("postrst.dev_valid", 32'(dev_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
